idct_approximation_stream: RTL

Streaming inverse of the team's 2-point DCT approximation (forward: dct1 = (p1+p2)/2, dct2 = (p1−p2)/2). It accepts one coefficient pair per handshake and reconstructs p1 = c0 + c1 and p2 = c0 − c1, saturating each result to the signed DATA_W range. It emits the two pixels serially on a valid/ready stream and marks block boundaries with `pix_last`. It sits on the decode side of the image pipeline, after coefficient dequantisation and before the pixel line buffer.

---
 rtl/idct_approximation_stream_pkg.sv | 14 +
 rtl/idct_approximation_stream_sat_clip.sv | 21 ++
 rtl/idct_approximation_stream.sv | 114 +++++++++++
 3 files changed

// File: rtl/idct_approximation_stream_pkg.sv
// Shared definitions for the 2-point inverse DCT stream.
//   state_e        : emit FSM states
//   DEFAULT_DATA_W : default signed coefficient / pixel width
//   SAT_CNT_W      : width of the clipped-pixel counter
package idct_pkg;
  localparam int DEFAULT_DATA_W = 8;
  localparam int SAT_CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT_P1 = 2'd1,
    EMIT_P2 = 2'd2
  } state_e;
endpackage

// File: rtl/idct_approximation_stream_sat_clip.sv
// Saturating narrow from DATA_W+1 to DATA_W signed bits.
//   din     : DATA_W+1 bit signed value
//   dout    : value clipped to the signed DATA_W range
//   clipped : high when din was outside that range
module sat_clip #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W:0]   din,
  output logic [DATA_W-1:0] dout,
  output logic              clipped
);
  // The value fits iff the two top bits agree (the extra bit is pure sign).
  assign clipped = din[DATA_W] ^ din[DATA_W-1];

  always_comb begin
    dout = din[DATA_W-1:0];
    if (clipped)
      dout = din[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}   // most negative
                         : {1'b0, {(DATA_W-1){1'b1}}};  // most positive
  end
endmodule

// File: rtl/idct_approximation_stream.sv
// Streaming inverse 2-point DCT approximation: p1 = c0 + c1, p2 = c0 - c1,
// each saturated to DATA_W, emitted serially (p1 then p2).
//   clk, rst           : clock, synchronous active-high reset
//   coef_valid/ready   : coefficient pair handshake, coef0 = c0, coef1 = c1
//   pix_valid/ready    : pixel stream handshake, pix_data = pixel
//   pix_last           : final pixel of each BLOCK_PAIRS-pair block
//   sat_count          : sticky-saturating count of clipped pixels
module idct_approximation_stream
  import idct_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int BLOCK_PAIRS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  input  logic [DATA_W-1:0]    coef0,
  input  logic [DATA_W-1:0]    coef1,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [DATA_W-1:0]    pix_data,
  output logic                 pix_last,
  output logic [SAT_CNT_W-1:0] sat_count
);
  localparam int CNT_W = (BLOCK_PAIRS > 1) ? $clog2(BLOCK_PAIRS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_PAIRS - 1);

  state_e                 state, state_nxt;
  logic [DATA_W-1:0]      p1_q, p2_q;
  logic [CNT_W-1:0]       pair_cnt;
  logic [SAT_CNT_W-1:0]   sat_q;
  logic                   accept, p2_done;
  logic [DATA_W:0]        sum, diff;
  logic [DATA_W-1:0]      sum_clip, diff_clip;
  logic                   sum_sat, diff_sat;
  logic [SAT_CNT_W:0]     sat_sum;

  // A new pair can land while the last pixel of the previous one leaves,
  // which keeps the stream at one pixel per cycle.
  assign coef_ready = !rst && (state == IDLE || (state == EMIT_P2 && pix_ready));
  assign accept     = coef_valid && coef_ready;
  assign p2_done    = (state == EMIT_P2) && pix_ready;

  // Sign-extend by one bit so sum/diff cannot overflow before clipping.
  assign sum  = {coef0[DATA_W-1], coef0} + {coef1[DATA_W-1], coef1};
  assign diff = {coef0[DATA_W-1], coef0} - {coef1[DATA_W-1], coef1};

  sat_clip #(.DATA_W(DATA_W)) u_clip_sum (
    .din(sum), .dout(sum_clip), .clipped(sum_sat)
  );
  sat_clip #(.DATA_W(DATA_W)) u_clip_diff (
    .din(diff), .dout(diff_clip), .clipped(diff_sat)
  );

  // One spare bit catches the carry out so the counter can stick at max.
  assign sat_sum = {1'b0, sat_q} + (SAT_CNT_W+1)'(sum_sat) + (SAT_CNT_W+1)'(diff_sat);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = EMIT_P1;
      EMIT_P1: if (pix_ready) state_nxt = EMIT_P2;
      EMIT_P2: if (pix_ready) state_nxt = accept ? EMIT_P1 : IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_last  = 1'b0;
    unique case (state)
      EMIT_P1: begin
        pix_valid = 1'b1;
        pix_data  = p1_q;
      end
      EMIT_P2: begin
        pix_valid = 1'b1;
        pix_data  = p2_q;
        pix_last  = (pair_cnt == CNT_MAX);
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q     <= '0;
      p2_q     <= '0;
      pair_cnt <= '0;
      sat_q    <= '0;
    end else begin
      if (accept) begin
        p1_q  <= sum_clip;
        p2_q  <= diff_clip;
        sat_q <= sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
      end
      if (p2_done)
        pair_cnt <= (pair_cnt == CNT_MAX) ? '0 : pair_cnt + CNT_W'(1);
    end
  end

  assign sat_count = sat_q;
endmodule
